pipeline_restoring_divider_module: RTL and testbench

PIPELINE_RESTORING_DIVIDER_MODULE -- requirements
Module: pipeline_restoring_divider_module

---
 rtl/pipeline_restoring_divider_module.sv | 142 ++++++++++++++
 tb/tb_pipeline_restoring_divider_module.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_restoring_divider_module.sv
// rtl/pipeline_restoring_divider_module.sv - 16/8 unsigned restoring divider, one step per clock
// DIVIDER_ZERO_CHECK_EN: divisor=0 bypasses CALC and reports div_zero one cycle after start.
module pipeline_restoring_divider_module (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] dvd_q, dvd_d;
  logic [7:0]  dvs_q, dvs_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] quotient_q, quotient_d;
  logic [7:0]  remainder_q, remainder_d;
  logic        accept;
  logic [8:0]  shifted;
  logic [7:0]  diff;
  logic        ge;
`ifdef DIVIDER_ZERO_CHECK_EN
  logic        pend_q, pend_d;
  logic        div_zero_q, div_zero_d;
`endif

  // When ge holds, the true difference is below the divisor, so 8 bits suffice.
  assign shifted = {rem_q, dvd_q[15]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[7:0] - dvs_q;

`ifdef DIVIDER_ZERO_CHECK_EN
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE)) && !pend_q;
  assign div_zero = div_zero_q;
`else
  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign div_zero = 1'b0;
`endif

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    pend_d      = pend_q;
    div_zero_d  = div_zero_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
`ifdef DIVIDER_ZERO_CHECK_EN
        if (pend_q) begin
          state_d     = DONE;
          pend_d      = 1'b0;
          quotient_d  = 16'hFFFF;
          remainder_d = dvd_q[7:0];
          div_zero_d  = 1'b1;
        end else
`endif
        if (accept) begin
          state_d = CALC;
          cnt_d   = 5'd0;
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = 8'd0;
          quo_d   = 16'd0;
`ifdef DIVIDER_ZERO_CHECK_EN
          if (divisor == 8'd0) begin
            state_d = IDLE;
            pend_d  = 1'b1;
          end
`endif
        end
      end
      CALC: begin
        if (cnt_q == 5'd16) begin
          state_d     = DONE;
          quotient_d  = quo_q;
          remainder_d = rem_q;
`ifdef DIVIDER_ZERO_CHECK_EN
          div_zero_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
          rem_d = ge ? diff : shifted[7:0];
          quo_d = {quo_q[14:0], ge};
          dvd_d = {dvd_q[14:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      dvd_q       <= 16'd0;
      dvs_q       <= 8'd0;
      rem_q       <= 8'd0;
      quo_q       <= 16'd0;
      quotient_q  <= 16'd0;
      remainder_q <= 8'd0;
`ifdef DIVIDER_ZERO_CHECK_EN
      pend_q      <= 1'b0;
      div_zero_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIVIDER_ZERO_CHECK_EN
      pend_q      <= pend_d;
      div_zero_q  <= div_zero_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipeline_restoring_divider_module.sv
// tb/tb_pipeline_restoring_divider_module.sv - randomized self-checking bench for the restoring divider
// Define DIVIDER_ZERO_CHECK_EN here as well when building the zero-check variant.
module tb_pipeline_restoring_divider_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

`ifdef DIVIDER_ZERO_CHECK_EN
  localparam int   ZLAT  = 1;
  localparam logic ZFLAG = 1'b1;
`else
  localparam int   ZLAT  = 17;
  localparam logic ZFLAG = 1'b0;
`endif

  pipeline_restoring_divider_module dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r,
                                output logic z, output int lat);
    if (b == 8'd0) begin
      q   = 16'hFFFF;
      r   = a[7:0];
      z   = ZFLAG;
      lat = ZLAT;
    end else begin
      q   = 16'(a / b);
      r   = 8'(a % b);
      z   = 1'b0;
      lat = 17;
    end
  endfunction

  // Launches one operation and waits (bounded) for done; reports what was seen.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       output int lat, output logic [15:0] q, output logic [7:0] r,
                       output logic z, output logic held, output logic busy_seen);
    logic [15:0] q0;
    logic [7:0]  r0;
    q0        = quotient;
    r0        = remainder;
    held      = 1'b1;
    busy_seen = 1'b0;
    lat       = -1;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    dividend  = $urandom_range(0, 65535);
    divisor   = $urandom_range(0, 255);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy) busy_seen = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
      if (quotient !== q0 || remainder !== r0) held = 1'b0;
    end
    q = quotient;
    r = remainder;
    z = div_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    dividend = 16'd0;
    divisor  = 8'd0;
    tick();
    tick();
    total++;
    if ({busy, done, quotient, remainder, div_zero} !== 27'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b, want all zero",
               busy, done, quotient, remainder, div_zero);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k <= 16) begin
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || quotient !== 16'd0) begin
          bad++;
          $display("FAIL basic_calc_k%0d: got busy=%b done=%b q=%0d, want 1 0 0", k, busy, done, quotient);
        end
      end else begin
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || quotient !== 16'd142 || remainder !== 8'd6 || div_zero !== 1'b0) begin
          bad++;
          $display("FAIL basic_done: got done=%b busy=%b q=%0d r=%0d dz=%b, want 1 0 142 6 0",
                   done, busy, quotient, remainder, div_zero);
        end
      end
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || quotient !== 16'd142 || remainder !== 8'd6) begin
      bad++;
      $display("FAIL basic_after: got done=%b busy=%b q=%0d r=%0d, want 0 0 142 6", done, busy, quotient, remainder);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] va [0:1];
    logic [7:0]  vb [0:1];
    logic [15:0] q, eq;
    logic [7:0]  r, er;
    logic        z, ez, held, bs;
    int          lat, elat;
    va[0] = 16'hFFFF; vb[0] = 8'hFF;
    va[1] = 16'd5;    vb[1] = 8'd9;
    for (int i = 0; i < 2; i++) begin
      do_op(va[i], vb[i], lat, q, r, z, held, bs);
      model(va[i], vb[i], eq, er, ez, elat);
      total++;
      if (lat != elat || q !== eq || r !== er || z !== ez || !held) begin
        bad++;
        $display("FAIL vector_%0d: got lat=%0d q=%0d r=%0d dz=%b held=%b, want %0d %0d %0d %b 1",
                 i, lat, q, r, z, held, elat, eq, er, ez);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, q, eq;
    logic [7:0]  b, r, er;
    logic        z, ez, held, bs;
    int          lat, elat;
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = (i % 10 == 9) ? 8'd0 : 8'($urandom_range(1, 255));
      do_op(a, b, lat, q, r, z, held, bs);
      model(a, b, eq, er, ez, elat);
      total++;
      if (lat != elat || q !== eq || r !== er || z !== ez || !held || bs !== (elat == 17)) begin
        bad++;
        $display("FAIL random_%0d %0d/%0d: got lat=%0d q=%0d r=%0d dz=%b held=%b busy=%b, want %0d %0d %0d %b 1 %b",
                 i, a, b, lat, q, r, z, held, bs, elat, eq, er, ez, (elat == 17));
      end
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] q;
    logic [7:0]  r;
    logic        z, held, bs;
    int          lat;
    do_op(16'h1234, 8'd0, lat, q, r, z, held, bs);
    total++;
    if (lat != ZLAT || q !== 16'hFFFF || r !== 8'h34 || z !== ZFLAG || bs !== (ZLAT == 17)) begin
      bad++;
      $display("FAIL div_zero: got lat=%0d q=%h r=%h dz=%b busy=%b, want %0d ffff 34 %b %b",
               lat, q, r, z, bs, ZLAT, ZFLAG, (ZLAT == 17));
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    lat      = -1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        dividend = 16'd100;
        divisor  = 8'd3;
        start    = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat != 17 || quotient !== 16'd142 || remainder !== 8'd6) begin
      bad++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d, want 17 142 6", lat, quotient, remainder);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, quotient, remainder, div_zero} !== 27'd0) begin
      bad++;
      $display("FAIL reset_abort_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all zero",
               busy, done, quotient, remainder, div_zero);
    end
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort_quiet: got activity=%b, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          lat1, lat2, elat;
    lat1     = -1;
    lat2     = -1;
    dividend = 16'd1000;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    dividend = 16'd5000;
    divisor  = 8'd13;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat1 = k;
        break;
      end
    end
    total++;
    if (lat1 != 17 || quotient !== 16'd142 || remainder !== 8'd6) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d, want 17 142 6", lat1, quotient, remainder);
    end
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_gap: got busy=%b done=%b, want 1 0", busy, done);
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat2 = k;
        break;
      end
    end
    model(16'd5000, 8'd13, eq, er, ez, elat);
    total++;
    if (lat2 != elat || quotient !== eq || remainder !== er || div_zero !== ez) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d dz=%b, want %0d %0d %0d %b",
               lat2, quotient, remainder, div_zero, elat, eq, er, ez);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
